// File: rtl/core_pkg.sv
// Shared core definitions: instruction width, NOP encoding and the loader FSM states.
package core_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } ld_state_e;

endpackage

// File: rtl/ins_mem_array.sv
// Single-write, single-read synchronous RAM with a registered read port.
module ins_mem_array
  import core_pkg::*;
#(
  parameter int                DATA_W = INSTR_W,
  parameter int                DEPTH  = 32,
  parameter int                ADDR_W = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] FILL   = DATA_W'(NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rnop,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // rnop substitutes FILL so masked reads never expose stale contents
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = rnop ? FILL : mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= FILL;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ins_mem_loader.sv
// Instruction memory with a NOP clear sweep, a valid/ready program loader and a
// one-cycle registered fetch port that masks addresses beyond the loaded program.
module ins_mem_loader
  import core_pkg::*;
#(
  parameter int                DATA_W   = INSTR_W,
  parameter int                ADDR_W   = 5,
  parameter int                DEPTH    = 1 << ADDR_W,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  output logic [ADDR_W:0]   prog_len,
  output logic              load_done,
  output logic              busy
);

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ld_state_e         state_d, state_q;
  logic [ADDR_W-1:0] clr_ptr_d, clr_ptr_q;
  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_W:0]   prog_len_d, prog_len_q;
  logic              ld_ready_d, ld_ready_q;
  logic              fetch_valid_d, fetch_valid_q;
  logic              fetch_err_d, fetch_err_q;
  logic              load_done_d, load_done_q;
  logic              busy_d, busy_q;

  logic              mem_we, mem_re, mem_rnop, in_range, ld_accept;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Next-state logic; also steers the single RAM write port between sweep and loader
  always_comb begin
    state_d       = state_q;
    clr_ptr_d     = clr_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    prog_len_d    = prog_len_q;
    fetch_valid_d = 1'b0;
    fetch_err_d   = fetch_err_q;
    load_done_d   = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = wr_ptr_q;
    mem_wdata     = ld_data;
    mem_re        = 1'b0;
    mem_rnop      = 1'b0;
    in_range      = ({1'b0, fetch_addr} < prog_len_q);
    ld_accept     = (state_q == ST_LOAD) && mode && ld_valid && ld_ready_q;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = NOP_WORD;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (mode) begin
          state_d    = ST_LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (!mode) begin
          state_d     = ST_RUN;
          load_done_d = 1'b1;
        end else if (ld_accept) begin
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
          prog_len_d = prog_len_q + (ADDR_W+1)'(1);
        end
      end
      ST_RUN: begin
        if (fetch_req) begin
          fetch_valid_d = 1'b1;
          fetch_err_d   = !in_range;
          mem_re        = 1'b1;
          mem_rnop      = !in_range;
        end
        // A request made on the switch cycle is still answered next edge
        if (mode) begin
          state_d    = ST_LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    busy_d     = (state_d == ST_CLEAR);
    ld_ready_d = (state_d == ST_LOAD) && (prog_len_d < DEPTH_L);
  end

  // State, pointers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      clr_ptr_q     <= '0;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      ld_ready_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      load_done_q   <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      clr_ptr_q     <= clr_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      prog_len_q    <= prog_len_d;
      ld_ready_q    <= ld_ready_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      load_done_q   <= load_done_d;
      busy_q        <= busy_d;
    end
  end

  ins_mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .FILL  (NOP_WORD)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (mem_re),
    .rnop (mem_rnop),
    .raddr(fetch_addr),
    .rdata(fetch_data)
  );

  assign ld_ready    = ld_ready_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_err   = fetch_err_q;
  assign prog_len    = prog_len_q;
  assign load_done   = load_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed, table-driven bench for ins_mem_loader (default 32x32 configuration).
module tb_ins_mem_loader;

  logic        clk = 1'b0;
  logic        rst, mode, ld_valid, fetch_req;
  logic [31:0] ld_data;
  logic [4:0]  fetch_addr;
  logic        ld_ready, fetch_valid, fetch_err, load_done, busy;
  logic [31:0] fetch_data;
  logic [5:0]  prog_len;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mode;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        fetch_req;
    logic [4:0]  fetch_addr;
    logic        e_fv;
    logic [31:0] e_data;
    logic        e_err;
    logic        e_rdy;
    logic [5:0]  e_len;
    logic        e_done;
  } vec_t;

  vec_t vecs [11];

  ins_mem_loader dut (
    .clk(clk), .rst(rst), .mode(mode), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .prog_len(prog_len), .load_done(load_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sweep();
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("sweep_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic fetch(input logic [4:0] a, input logic [31:0] e_data, input logic e_err, input string nm);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req = 1'b0;
    chk({nm, "_fv"}, {31'd0, fetch_valid}, 32'd1);
    chk({nm, "_data"}, fetch_data, e_data);
    chk({nm, "_err"}, {31'd0, fetch_err}, {31'd0, e_err});
  endtask

  initial begin
    int n;
    //            mode  vld   data          req   addr   fv    data          err   rdy   len    done
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,        1'b1, 1'b1, 6'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 32'h14080002, 1'b0, 5'd0, 1'b0, 32'h0,        1'b1, 1'b1, 6'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 32'h14090001, 1'b1, 5'd0, 1'b0, 32'h0,        1'b1, 1'b1, 6'd2, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h2109000A, 1'b0, 5'd0, 1'b0, 32'h0,        1'b1, 1'b1, 6'd3, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 6'd3, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 5'd1, 1'b1, 32'h14090001, 1'b0, 1'b0, 6'd3, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 5'd3, 1'b1, 32'h0,        1'b1, 1'b0, 6'd3, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 5'd0, 1'b1, 32'h14080002, 1'b0, 1'b0, 6'd3, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 5'd1, 1'b1, 32'h14090001, 1'b0, 1'b0, 6'd3, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 5'd2, 1'b1, 32'h2109000A, 1'b0, 1'b0, 6'd3, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h2109000A, 1'b0, 1'b0, 6'd3, 1'b0};

    rst = 1'b1; mode = 1'b0; ld_valid = 1'b0; ld_data = 32'h0;
    fetch_req = 1'b0; fetch_addr = 5'd0;
    tick(); tick();

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
    chk("rst_data", fetch_data, 32'h0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_len", {26'd0, prog_len}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);

    // Sweep length: busy must stay high for exactly 32 cycles
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    chk("busy_cycles", n, 32'd32);

    tick();  // IDLE -> RUN
    fetch(5'd7, 32'h0, 1'b1, "empty_fetch7");
    tick();
    chk("idle_fv", {31'd0, fetch_valid}, 32'd0);

    // Table: load 3 words, end session, then single and back-to-back fetches
    for (int i = 0; i < 11; i++) begin
      mode       = vecs[i].mode;
      ld_valid   = vecs[i].ld_valid;
      ld_data    = vecs[i].ld_data;
      fetch_req  = vecs[i].fetch_req;
      fetch_addr = vecs[i].fetch_addr;
      tick();
      chk($sformatf("v%0d_fv", i), {31'd0, fetch_valid}, {31'd0, vecs[i].e_fv});
      chk($sformatf("v%0d_data", i), fetch_data, vecs[i].e_data);
      chk($sformatf("v%0d_err", i), {31'd0, fetch_err}, {31'd0, vecs[i].e_err});
      chk($sformatf("v%0d_rdy", i), {31'd0, ld_ready}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_len", i), {26'd0, prog_len}, {26'd0, vecs[i].e_len});
      chk($sformatf("v%0d_done", i), {31'd0, load_done}, {31'd0, vecs[i].e_done});
    end
    fetch_req = 1'b0;

    // Full load: 32 words, then overflow attempts must be refused
    mode = 1'b1;
    tick();
    chk("full_start_rdy", {31'd0, ld_ready}, 32'd1);
    chk("full_start_len", {26'd0, prog_len}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h1000_0000 + i;
      tick();
    end
    chk("full_rdy", {31'd0, ld_ready}, 32'd0);
    chk("full_len", {26'd0, prog_len}, 32'd32);
    ld_data = 32'hDEADBEEF;
    tick(); tick(); tick();
    chk("ovf_rdy", {31'd0, ld_ready}, 32'd0);
    chk("ovf_len", {26'd0, prog_len}, 32'd32);
    mode = 1'b0; ld_valid = 1'b0;
    tick();
    chk("full_done", {31'd0, load_done}, 32'd1);
    fetch(5'd0, 32'h1000_0000, 1'b0, "full_f0");
    fetch(5'd31, 32'h1000_001F, 1'b0, "full_f31");

    // Reset mid-load after 2 of 5 words
    mode = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hA000_0000 + i;
      tick();
    end
    chk("mid_len", {26'd0, prog_len}, 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    chk("mid_rst_len", {26'd0, prog_len}, 32'd0);
    chk("mid_rst_rdy", {31'd0, ld_ready}, 32'd0);
    tick();
    rst = 1'b0; mode = 1'b0; ld_valid = 1'b0;
    wait_sweep();
    tick();  // IDLE -> RUN
    fetch(5'd0, 32'h0, 1'b1, "post_rst_f0");

    // RUN -> LOAD on the same cycle as a fetch
    mode = 1'b1;
    tick();
    ld_valid = 1'b1; ld_data = 32'h1111_1111; tick();
    ld_data = 32'h2222_2222; tick();
    mode = 1'b0; ld_valid = 1'b0; tick();
    chk("pre_len", {26'd0, prog_len}, 32'd2);
    mode = 1'b1;
    fetch(5'd1, 32'h2222_2222, 1'b0, "switch_fetch");
    chk("switch_len", {26'd0, prog_len}, 32'd0);
    chk("switch_rdy", {31'd0, ld_ready}, 32'd1);
    ld_valid = 1'b1; ld_data = 32'h0; tick();
    chk("reload_len", {26'd0, prog_len}, 32'd1);
    mode = 1'b0; ld_valid = 1'b0; tick();
    chk("reload_done", {31'd0, load_done}, 32'd1);
    fetch(5'd1, 32'h0, 1'b1, "stale_f1");
    fetch(5'd0, 32'h0, 1'b0, "reload_f0");
    tick();
    chk("final_fv", {31'd0, fetch_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_mem_loader.md
Name: ins_mem_loader

Overview:
- Parametrised, fully synchronous instruction memory for the single-cycle/multi-cycle core.
- Replaces the fixed 32x32 preloaded store with a runtime program loader: a valid/ready stream path writes the program, and a registered fetch port serves the PC.
- A reset-time clear sweep fills the array with NOP, so fetches past the loaded program return NOP, never X.

Parameters:
- DATA_W, 32, instruction word width.
- ADDR_W, 5, address width.
- DEPTH, 1<<ADDR_W, number of words; must satisfy DEPTH <= 2**ADDR_W.
- NOP_WORD, 32'd0, value written by the clear sweep and returned for out-of-range fetches.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  1 = load program, 0 = run/fetch.
- ld_valid  in  1  loader word valid.
- ld_data  in  DATA_W  loader instruction word.
- ld_ready  out  1  block accepts a loader word this cycle.
- fetch_req  in  1  fetch request from the PC stage.
- fetch_addr  in  ADDR_W  word address to fetch.
- fetch_valid  out  1  fetch_data/fetch_err valid; one-cycle pulse per request.
- fetch_data  out  DATA_W  fetched instruction.
- fetch_err  out  1  fetch_addr >= prog_len; fetch_data = NOP_WORD.
- prog_len  out  ADDR_W+1  number of words in the current program.
- load_done  out  1  one-cycle pulse when a load session ends.
- busy  out  1  high during the clear sweep.

Behaviour:
- Reset (async, rst=1): state=CLEAR, clr_ptr=0, wr_ptr=0, prog_len=0.
  - Outputs: ld_ready=0, fetch_valid=0, fetch_data=NOP_WORD, fetch_err=0, load_done=0, busy=1.
  - The memory array itself is not reset.
- States: CLEAR, IDLE, LOAD, RUN.
- CLEAR:
  - Each cycle writes mem[clr_ptr]=NOP_WORD and increments clr_ptr.
  - After DEPTH cycles, moves to IDLE; busy drops in the same edge.
  - All requests are ignored.
- IDLE:
  - mode=1 -> LOAD, with wr_ptr=0 and prog_len=0.
  - mode=0 -> RUN.
- LOAD:
  - ld_ready = (prog_len < DEPTH).
  - On ld_valid && ld_ready: mem[wr_ptr]=ld_data, wr_ptr++, prog_len++.
  - Full: ld_ready=0; further words are not accepted and not written. No wrap-around.
  - When mode falls to 0: load_done=1 for one cycle, state -> RUN. A word offered in that same cycle is not accepted.
- RUN:
  - fetch_req sampled at edge N -> at edge N+1, fetch_valid=1 and fetch_data=mem[fetch_addr], fetch_err=0.
  - If fetch_addr >= prog_len: fetch_data=NOP_WORD, fetch_err=1.
  - Latency is exactly 1 cycle; back-to-back requests are served every cycle.
  - fetch_valid is 0 in any cycle with no request at the previous edge.
  - fetch_data holds its last value when fetch_valid=0.
- RUN -> LOAD when mode=1:
  - prog_len and wr_ptr reset to 0.
  - A fetch_req in the same cycle is still served on the next edge.
  - Stale words beyond the new prog_len stay in memory but are masked by fetch_err/NOP.
- fetch_req outside RUN: ignored, no fetch_valid.
- ld_valid outside LOAD: ignored, ld_ready=0.
- Reset mid-load or mid-fetch: returns to CLEAR, prog_len=0, and any pending fetch_valid is dropped.
- Width rules:
  - prog_len is ADDR_W+1 bits so it can hold DEPTH.
  - The fetch_addr < prog_len compare is unsigned, with fetch_addr zero-extended.

Decomposition:
- Shared package (core_pkg), holding:
  - the state enum (CLEAR, IDLE, LOAD, RUN);
  - the NOP constant;
  - the instruction width constant, also used by the decoder.
- One natural sub-module: ins_mem_array.
  - Single-port-write, single-port-read synchronous RAM.
  - Registered read, parametrised by DATA_W/DEPTH.
- The FSM, pointers and the range check stay in ins_mem_loader.

Test Plan:
- Reset then wait: busy=1 for exactly 32 cycles, then 0. Fetch addr 7 in RUN -> fetch_valid next cycle, data=0, fetch_err=1.
- Load 3 words 0x14080002, 0x14090001, 0x2109000A with ld_valid held; mode->0 -> load_done one pulse, prog_len=3. Fetch addr 1 -> 0x14090001, err=0. Fetch addr 3 -> 0, err=1.
- Back-to-back fetches of addr 0,1,2 on consecutive cycles -> three consecutive fetch_valid cycles with the matching words, in order.
- Load 32 words then keep ld_valid high with 0xDEADBEEF -> ld_ready=0 after word 32, prog_len=32, mem[0] unchanged.
- Assert rst for 1 cycle after 2 of 5 load words -> immediately busy=1, prog_len=0. After the sweep, fetch addr 0 -> 0, err=1.
- In RUN, fetch_req and mode=1 in the same cycle -> the fetch is served next cycle, state becomes LOAD, prog_len=0. A new 1-word load of 0x0 gives prog_len=1, and the old addr 1 returns err=1.
